wb_stage: RTL and testbench

- Writeback stage directly downstream of the memory stage: pipeline register between memory stage outputs and the register file.
- Captures each retiring instruction, formats load data (byte/half/word, signed/unsigned) and drives the GPR write port.
- Owns the architectural HI/LO registers and an instruction-retire counter.
- Suppresses all architectural writes for excepting instructions and converts memory-stage stalls/flushes into bubbles.

---
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: registers the retiring memory-stage instruction, formats load data,
// drives the GPR write port and owns the HI/LO registers and the retire counter.
module wb_stage #(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    MemtoRegW,
    input  logic                    RegWriteW,
    input  logic                    HI_LO_write_enableW,
    input  logic [63:0]             HI_LO_dataW,
    input  logic [31:0]             ALUoutW,
    input  logic [6:0]              WriteRegisterW,
    input  logic [31:0]             PCout,
    input  logic [2:0]              MemReadTypeW,
    input  logic [3:0]              exception_out,
    input  logic                    is_ds_out,
    input  logic [31:0]             Memdata,
    input  logic                    stall,
    input  logic                    CLR,
    output logic                    rf_we,
    output logic [6:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic [31:0]             hi,
    output logic [31:0]             lo,
    output logic                    wb_valid,
    output logic [31:0]             wb_pc,
    output logic [3:0]              wb_exception,
    output logic                    wb_is_ds,
    output logic [RETIRE_CNT_W-1:0] retire_cnt
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sext;
    logic [31:0] result;

    logic        reg_write_q;
    logic        hilo_we_q;
    logic [63:0] hilo_data_q;
    logic        capture;
    logic        no_exc;

    // NOTE: every variable assigned in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        ld_byte = Memdata[7:0];
        case (ALUoutW[1:0])
            2'd1:    ld_byte = Memdata[15:8];
            2'd2:    ld_byte = Memdata[23:16];
            2'd3:    ld_byte = Memdata[31:24];
            default: ld_byte = Memdata[7:0];
        endcase
        ld_half = ALUoutW[1] ? Memdata[31:16] : Memdata[15:0];
        sext    = ~MemReadTypeW[2];

        result = ALUoutW;
        if (MemtoRegW) begin
            case (MemReadTypeW[1:0])
                2'b00:   result = {{24{sext & ld_byte[7]}}, ld_byte};
                2'b01:   result = {{16{sext & ld_half[15]}}, ld_half};
                2'b10:   result = Memdata;
                default: result = 32'd0;
            endcase
        end
    end

    assign capture = ~CLR & ~stall;
    assign no_exc  = (wb_exception == 4'd0);
    assign rf_we   = wb_valid & reg_write_q & no_exc & (rf_waddr != 7'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wb_valid     <= 1'b0;
            wb_pc        <= 32'd0;
            wb_exception <= 4'd0;
            wb_is_ds     <= 1'b0;
            rf_waddr     <= 7'd0;
            rf_wdata     <= 32'd0;
            reg_write_q  <= 1'b0;
            hilo_we_q    <= 1'b0;
            hilo_data_q  <= 64'd0;
        end else if (capture) begin
            wb_valid     <= 1'b1;
            wb_pc        <= PCout;
            wb_exception <= exception_out;
            wb_is_ds     <= is_ds_out;
            rf_waddr     <= WriteRegisterW;
            rf_wdata     <= result;
            reg_write_q  <= RegWriteW;
            hilo_we_q    <= HI_LO_write_enableW;
            hilo_data_q  <= HI_LO_dataW;
        end else begin
            // Bubble: only the enables need clearing; datapath fields are don't-care.
            wb_valid     <= 1'b0;
            reg_write_q  <= 1'b0;
            hilo_we_q    <= 1'b0;
        end
    end

    // HI/LO and the counter act on the instruction already sitting in WB.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            retire_cnt <= '0;
        end else begin
            if (wb_valid && hilo_we_q && no_exc) begin
                hi <= hilo_data_q[63:32];
                lo <= hilo_data_q[31:0];
            end
            if (wb_valid && no_exc)
                retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: load formatting, stall/flush bubbles,
// exception suppression, HI/LO timing, asynchronous reset and counter wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        MemtoRegW, RegWriteW, HI_LO_write_enableW;
    logic [63:0] HI_LO_dataW;
    logic [31:0] ALUoutW, PCout, Memdata;
    logic [6:0]  WriteRegisterW;
    logic [2:0]  MemReadTypeW;
    logic [3:0]  exception_out;
    logic        is_ds_out, stall, CLR;

    logic        rf_we, wb_valid, wb_is_ds;
    logic [6:0]  rf_waddr;
    logic [31:0] rf_wdata, hi, lo, wb_pc;
    logic [3:0]  wb_exception;
    logic [31:0] retire_cnt;

    logic        rf_we_n, wb_valid_n, wb_is_ds_n;
    logic [6:0]  rf_waddr_n;
    logic [31:0] rf_wdata_n, hi_n, lo_n, wb_pc_n;
    logic [3:0]  wb_exception_n;
    logic [3:0]  retire_cnt_n;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of what WB holds, used only to predict the retire count.
    logic        m_valid;
    logic [3:0]  m_exc;
    logic [31:0] exp_cnt;
    logic [31:0] cnt_before;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .aresetn(aresetn), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
        .HI_LO_write_enableW(HI_LO_write_enableW), .HI_LO_dataW(HI_LO_dataW), .ALUoutW(ALUoutW),
        .WriteRegisterW(WriteRegisterW), .PCout(PCout), .MemReadTypeW(MemReadTypeW),
        .exception_out(exception_out), .is_ds_out(is_ds_out), .Memdata(Memdata), .stall(stall),
        .CLR(CLR), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi(hi), .lo(lo),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exception(wb_exception), .wb_is_ds(wb_is_ds),
        .retire_cnt(retire_cnt)
    );

    wb_stage #(.RETIRE_CNT_W(4)) dut_narrow (
        .clk(clk), .aresetn(aresetn), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
        .HI_LO_write_enableW(HI_LO_write_enableW), .HI_LO_dataW(HI_LO_dataW), .ALUoutW(ALUoutW),
        .WriteRegisterW(WriteRegisterW), .PCout(PCout), .MemReadTypeW(MemReadTypeW),
        .exception_out(exception_out), .is_ds_out(is_ds_out), .Memdata(Memdata), .stall(stall),
        .CLR(CLR), .rf_we(rf_we_n), .rf_waddr(rf_waddr_n), .rf_wdata(rf_wdata_n), .hi(hi_n),
        .lo(lo_n), .wb_valid(wb_valid_n), .wb_pc(wb_pc_n), .wb_exception(wb_exception_n),
        .wb_is_ds(wb_is_ds_n), .retire_cnt(retire_cnt_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        MemtoRegW = 0; RegWriteW = 0; HI_LO_write_enableW = 0; HI_LO_dataW = 64'd0;
        ALUoutW = 32'd0; WriteRegisterW = 7'd0; PCout = 32'd0; MemReadTypeW = 3'd0;
        exception_out = 4'd0; is_ds_out = 0; Memdata = 32'd0; stall = 0; CLR = 0;
    endtask

    // One rising edge; outputs are sampled 1 ns later, well away from the edge.
    task automatic step();
        if (m_valid && m_exc == 4'd0) exp_cnt = exp_cnt + 1;
        if (!CLR && !stall) begin
            m_valid = 1'b1;
            m_exc   = exception_out;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m_valid = 1'b0;
        m_exc   = 4'd0;
        exp_cnt = 32'd0;
        @(posedge clk);
        #3;
        aresetn = 1'b1;
        #1;
    endtask

    task automatic load(input logic [31:0] data, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [6:0] rd);
        clear_inputs();
        MemtoRegW = 1; RegWriteW = 1; Memdata = data; ALUoutW = addr;
        MemReadTypeW = typ; WriteRegisterW = rd;
    endtask

    initial begin
        clear_inputs();
        m_valid = 1'b0; m_exc = 4'd0; exp_cnt = 32'd0;
        aresetn = 1'b0;
        #2;
        check("reset_wb_valid", wb_valid, 0);
        check("reset_rf_we", rf_we, 0);
        check("reset_retire_cnt", retire_cnt, 0);
        do_reset();

        // Signed then unsigned byte from lane 2 of 0x12F45678.
        load(32'h12F4_5678, 32'h0000_1002, 3'b000, 7'd5);
        PCout = 32'h0000_0100; is_ds_out = 1;
        step();
        check("sbyte_rf_we", rf_we, 1);
        check("sbyte_waddr", rf_waddr, 5);
        check("sbyte_wdata", rf_wdata, 32'hFFFF_FFF4);
        check("sbyte_pc", wb_pc, 32'h0000_0100);
        check("sbyte_is_ds", wb_is_ds, 1);
        check("sbyte_cnt", retire_cnt, 0);
        load(32'h12F4_5678, 32'h0000_1002, 3'b100, 7'd5);
        step();
        check("ubyte_wdata", rf_wdata, 32'h0000_00F4);
        check("ubyte_cnt", retire_cnt, 1);

        // Halfword lanes (ALUoutW[0] ignored), word, reserved type, ALU result.
        load(32'h8001_7FFE, 32'h0000_0003, 3'b001, 7'd6);
        step();
        check("shalf_hi_lane", rf_wdata, 32'hFFFF_8001);
        load(32'h8001_7FFE, 32'h0000_0001, 3'b101, 7'd6);
        step();
        check("uhalf_lo_lane", rf_wdata, 32'h0000_7FFE);
        load(32'h8001_7FFE, 32'h0000_0000, 3'b001, 7'd6);
        step();
        check("shalf_lo_lane", rf_wdata, 32'h0000_7FFE);
        load(32'h8001_7FFE, 32'h0000_0000, 3'b010, 7'd6);
        step();
        check("word", rf_wdata, 32'h8001_7FFE);
        load(32'h8001_7FFE, 32'h0000_0000, 3'b011, 7'd6);
        step();
        check("reserved_type", rf_wdata, 32'd0);
        load(32'h8001_7FFE, 32'hCAFE_0003, 3'b000, 7'd8);
        MemtoRegW = 0;
        step();
        check("alu_result", rf_wdata, 32'hCAFE_0003);
        check("alu_waddr", rf_waddr, 8);
        check("alu_cnt", retire_cnt, exp_cnt);

        // Stall for three cycles: bubbles, then exactly one write.
        load(32'h0000_00AA, 32'h0, 3'b100, 7'd7);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", wb_valid, 0);
            check("stall_rf_we", rf_we, 0);
        end
        cnt_before = retire_cnt;
        stall = 0;
        step();
        check("unstall_rf_we", rf_we, 1);
        check("unstall_wdata", rf_wdata, 32'h0000_00AA);
        stall = 1;
        step();
        check("post_stall_rf_we", rf_we, 0);
        check("stall_cnt_plus1", retire_cnt, cnt_before + 1);
        check("stall_cnt_model", retire_cnt, exp_cnt);

        // Flush beats stall.
        load(32'h1234_5678, 32'h0, 3'b010, 7'd3);
        CLR = 1; stall = 1;
        step();
        check("flush_valid", wb_valid, 0);
        check("flush_rf_we", rf_we, 0);

        // Excepting instruction: visible but architecturally silent.
        cnt_before = retire_cnt;
        clear_inputs();
        exception_out = 4'd4; RegWriteW = 1; HI_LO_write_enableW = 1;
        HI_LO_dataW = 64'h1111_2222_3333_4444; WriteRegisterW = 7'd9; PCout = 32'h200;
        step();
        check("exc_valid", wb_valid, 1);
        check("exc_code", wb_exception, 4);
        check("exc_rf_we", rf_we, 0);
        clear_inputs();
        stall = 1;
        step();
        check("exc_hi", hi, 0);
        check("exc_lo", lo, 0);
        check("exc_cnt", retire_cnt, cnt_before);

        // HI/LO write one cycle after capture; r0 destination suppresses rf_we.
        clear_inputs();
        HI_LO_write_enableW = 1; HI_LO_dataW = 64'hDEAD_BEEF_0123_4567;
        RegWriteW = 1; WriteRegisterW = 7'd0;
        step();
        check("r0_rf_we", rf_we, 0);
        check("hilo_no_bypass", hi, 0);
        clear_inputs();
        stall = 1;
        step();
        check("hilo_hi", hi, 32'hDEAD_BEEF);
        check("hilo_lo", lo, 32'h0123_4567);
        check("hilo_cnt", retire_cnt, exp_cnt);

        // Asynchronous reset between edges discards the in-flight HI/LO write.
        clear_inputs();
        HI_LO_write_enableW = 1; HI_LO_dataW = 64'h5555_6666_7777_8888;
        RegWriteW = 1; WriteRegisterW = 7'd4; PCout = 32'h300; exception_out = 4'd2;
        step();
        check("pre_reset_valid", wb_valid, 1);
        exception_out = 4'd0;
        step();
        check("pre_reset_valid2", wb_valid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_valid", wb_valid, 0);
        check("async_rf_we", rf_we, 0);
        check("async_waddr", rf_waddr, 0);
        check("async_wdata", rf_wdata, 0);
        check("async_hi", hi, 0);
        check("async_lo", lo, 0);
        check("async_pc", wb_pc, 0);
        check("async_exc", wb_exception, 0);
        check("async_cnt", retire_cnt, 0);
        do_reset();
        check("after_reset_hi", hi, 0);
        check("after_reset_valid", wb_valid, 0);

        // 17 back-to-back retirements: 32-bit counter reads 17, 4-bit wraps to 1.
        clear_inputs();
        for (int i = 0; i < 17; i++) begin
            PCout = 32'h400 + 32'(i * 4);
            step();
        end
        stall = 1;
        step();
        check("wrap_cnt32", retire_cnt, 17);
        check("wrap_cnt4", retire_cnt_n, 4'd1);
        check("wrap_model", retire_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
